// File: rtl/mac_psum_accum_ctrl_if.sv
// Handshake and data bundle between mac_psum_accum_ctrl, the MAC array, the accumulator
// and the layer controller. The controller itself connects through the master modport.
interface mac_psum_accum_ctrl_if #(
    parameter int MAX_LEN = 64,
    parameter int PASS_W  = 8
);
    localparam int LEN_W = $clog2(MAX_LEN);

    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [LEN_W-1:0]  i_cmd_len_m1;
    logic [PASS_W-1:0] i_cmd_pass_m1;
    logic [31:0]       i_cmd_bias;

    logic              i_psum_valid;
    logic              o_psum_ready;
    logic [31:0]       i_psum_data;

    logic              o_acc_psum_valid;
    logic              i_acc_psum_ready;
    logic [31:0]       o_acc_psum_data;
    logic              o_acc_inter_end;
    logic              o_acc_accum_end;

    logic              o_acc_bias_enable;
    logic              o_acc_bias_valid;
    logic              i_acc_bias_ready;
    logic [31:0]       o_acc_bias_data;

    logic              i_acc_out_valid;
    logic              i_acc_out_ready;

    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_cmd_valid, i_cmd_len_m1, i_cmd_pass_m1, i_cmd_bias,
        input  i_psum_valid, i_psum_data,
        input  i_acc_psum_ready, i_acc_bias_ready,
        input  i_acc_out_valid, i_acc_out_ready,
        output o_cmd_ready, o_psum_ready,
        output o_acc_psum_valid, o_acc_psum_data, o_acc_inter_end, o_acc_accum_end,
        output o_acc_bias_enable, o_acc_bias_valid, o_acc_bias_data,
        output o_busy, o_done
    );

    modport slave (
        output i_cmd_valid, i_cmd_len_m1, i_cmd_pass_m1, i_cmd_bias,
        output i_psum_valid, i_psum_data,
        output i_acc_psum_ready, i_acc_bias_ready,
        output i_acc_out_valid, i_acc_out_ready,
        input  o_cmd_ready, o_psum_ready,
        input  o_acc_psum_valid, o_acc_psum_data, o_acc_inter_end, o_acc_accum_end,
        input  o_acc_bias_enable, o_acc_bias_valid, o_acc_bias_data,
        input  o_busy, o_done
    );
endinterface

// File: rtl/mac_psum_accum_ctrl.sv
// Tile sequencer for mac_psum_accumulator: bias issue, psum pass-through with pass framing,
// output-beat counting and a done pulse. Define MAC_ACC_CTRL_BIAS_EN to enable the bias phase.
module mac_psum_accum_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int PASS_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mac_psum_accum_ctrl_if.master bus
);
    localparam int LEN_W = $clog2(MAX_LEN);

`ifdef MAC_ACC_CTRL_BIAS_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BIAS = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd2, DRAIN = 2'd3} state_e;
`endif

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [PASS_W-1:0] pass_m1_q, pass_m1_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [LEN_W:0]    ocnt_q, ocnt_d;
    logic              done_q, done_d;

    logic              in_stream;
    logic              cmd_fire;
    logic              psum_hs;
    logic              out_hs;
    logic              last_beat;
    logic              last_pass;
    logic [LEN_W:0]    len_p1;

    assign in_stream = (state_q == STREAM);
    assign cmd_fire  = (state_q == IDLE) && bus.i_cmd_valid;
    assign psum_hs   = in_stream && bus.i_psum_valid && bus.i_acc_psum_ready;
    assign out_hs    = ((state_q == STREAM) || (state_q == DRAIN))
                       && bus.i_acc_out_valid && bus.i_acc_out_ready;
    assign last_beat = (beat_q == len_q);
    assign last_pass = (pass_q == pass_m1_q);
    assign len_p1    = {1'b0, len_q} + (LEN_W+1)'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            pass_m1_q <= '0;
            pass_q    <= '0;
            ocnt_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            pass_m1_q <= pass_m1_d;
            pass_q    <= pass_d;
            ocnt_q    <= ocnt_d;
            done_q    <= done_d;
        end
    end

    // ocnt_d already includes this cycle's output handshake, so completion checks see it.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        beat_d    = beat_q;
        pass_m1_d = pass_m1_q;
        pass_d    = pass_q;
        ocnt_d    = out_hs ? (ocnt_q + (LEN_W+1)'(1)) : ocnt_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    len_d     = bus.i_cmd_len_m1;
                    pass_m1_d = bus.i_cmd_pass_m1;
                    beat_d    = '0;
                    pass_d    = '0;
                    ocnt_d    = '0;
`ifdef MAC_ACC_CTRL_BIAS_EN
                    state_d   = BIAS;
`else
                    state_d   = STREAM;
`endif
                end
            end
`ifdef MAC_ACC_CTRL_BIAS_EN
            BIAS: begin
                if (bus.i_acc_bias_ready) state_d = STREAM;
            end
`endif
            STREAM: begin
                if (psum_hs) begin
                    if (!last_beat) begin
                        beat_d = beat_q + LEN_W'(1);
                    end else begin
                        beat_d = '0;
                        // The pass counter holds on the final pass so it never wraps.
                        if (!last_pass) begin
                            pass_d = pass_q + PASS_W'(1);
                        end else if (ocnt_d == len_p1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_hs && (ocnt_d == len_p1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_cmd_ready      = (state_q == IDLE);
    assign bus.o_busy           = (state_q != IDLE);
    assign bus.o_done           = done_q;
    assign bus.o_acc_psum_valid = in_stream && bus.i_psum_valid;
    assign bus.o_psum_ready     = in_stream && bus.i_acc_psum_ready;
    assign bus.o_acc_psum_data  = in_stream ? bus.i_psum_data : 32'd0;
    assign bus.o_acc_inter_end  = in_stream && last_beat;
    assign bus.o_acc_accum_end  = in_stream && last_pass;

`ifdef MAC_ACC_CTRL_BIAS_EN
    logic [31:0] bias_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bias_q <= '0;
        end else if (cmd_fire) begin
            bias_q <= bus.i_cmd_bias;
        end
    end

    assign bus.o_acc_bias_enable = 1'b1;
    assign bus.o_acc_bias_valid  = (state_q == BIAS);
    assign bus.o_acc_bias_data   = bias_q;
`else
    logic unused_bias;
    assign unused_bias = ^{bus.i_cmd_bias, bus.i_acc_bias_ready};

    assign bus.o_acc_bias_enable = 1'b0;
    assign bus.o_acc_bias_valid  = 1'b0;
    assign bus.o_acc_bias_data   = 32'd0;
`endif
endmodule

// File: tb/tb_mac_psum_accum_ctrl.sv
// Self-checking bench for mac_psum_accum_ctrl: a table of tiles driven with random handshakes,
// checked against a beat-index reference model, plus reset and mid-tile abort sequences.
module tb_mac_psum_accum_ctrl;
    localparam int MAX_LEN = 64;
    localparam int PASS_W  = 8;
    localparam int LEN_W   = $clog2(MAX_LEN);
    localparam int NVEC    = 7;
`ifdef MAC_ACC_CTRL_BIAS_EN
    localparam logic BIAS_EN = 1'b1;
`else
    localparam logic BIAS_EN = 1'b0;
`endif

    typedef struct {
        int          len_m1;
        int          pass_m1;
        logic [31:0] bias;
        int          vpct;
        int          prdy;
        int          ordy;
        int          abort_at;
        int          exp_beats;
        int          exp_inter;
        int          exp_accum;
        int          exp_done;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mac_psum_accum_ctrl_if #(.MAX_LEN(MAX_LEN), .PASS_W(PASS_W)) bus ();

    mac_psum_accum_ctrl #(.MAX_LEN(MAX_LEN), .PASS_W(PASS_W)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic logic pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                                       name, act, act, exp, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.i_cmd_valid      = 1'b0;
        bus.i_cmd_len_m1     = '0;
        bus.i_cmd_pass_m1    = '0;
        bus.i_cmd_bias       = '0;
        bus.i_psum_valid     = 1'b0;
        bus.i_psum_data      = '0;
        bus.i_acc_psum_ready = 1'b0;
        bus.i_acc_bias_ready = 1'b0;
        bus.i_acc_out_valid  = 1'b0;
        bus.i_acc_out_ready  = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk1({tag, "_cmd_ready"}, bus.o_cmd_ready, 1'b1);
        chk1({tag, "_busy"}, bus.o_busy, 1'b0);
        chk1({tag, "_done"}, bus.o_done, 1'b0);
        chk1({tag, "_psum_valid"}, bus.o_acc_psum_valid, 1'b0);
        chk1({tag, "_psum_ready"}, bus.o_psum_ready, 1'b0);
        chk1({tag, "_inter_end"}, bus.o_acc_inter_end, 1'b0);
        chk1({tag, "_accum_end"}, bus.o_acc_accum_end, 1'b0);
        chk1({tag, "_bias_valid"}, bus.o_acc_bias_valid, 1'b0);
        chk1({tag, "_bias_enable"}, bus.o_acc_bias_enable, BIAS_EN);
        chkw({tag, "_bias_data"}, bus.o_acc_bias_data, 32'd0);
    endtask

    // Reference: global beat k of a tile sits at position k%L of pass k/L. Each final-pass
    // beat later yields one accumulator output; done follows the L-th output handshake.
    task automatic run_tile(input vec_t v, output int beats, output int n_ie,
                            output int n_ae, output int n_done);
        int   L, P, N, k, outs, pending, cyc, budget;
        logic in_bias, exp_stream, exp_done, finished, out_hs, ie_exp, ae_exp;
        L = v.len_m1 + 1;
        P = v.pass_m1 + 1;
        N = L * P;
        k = 0; outs = 0; pending = 0; cyc = 0;
        budget = 40 * N + 400;
        n_ie = 0; n_ae = 0; n_done = 0;
        in_bias = BIAS_EN; exp_done = 1'b0; finished = 1'b0;

        idle_inputs();
        bus.i_cmd_valid   = 1'b1;
        bus.i_cmd_len_m1  = LEN_W'(v.len_m1);
        bus.i_cmd_pass_m1 = PASS_W'(v.pass_m1);
        bus.i_cmd_bias    = v.bias;
        #1;
        chk1("cmd_ready_idle", bus.o_cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;

        while (!finished && cyc < budget) begin
            if (v.abort_at >= 0 && k == v.abort_at) break;
            bus.i_psum_valid     = (k < N) && pct(v.vpct);
            bus.i_psum_data      = $urandom;
            bus.i_acc_psum_ready = pct(v.prdy);
            bus.i_acc_bias_ready = pct(50);
            bus.i_acc_out_valid  = (pending > 0);
            bus.i_acc_out_ready  = pct(v.ordy);
            #1;
            chk1("done", bus.o_done, exp_done);
            if (exp_done) begin
                n_done++;
                finished = 1'b1;
                chk1("cmd_ready_after_done", bus.o_cmd_ready, 1'b1);
                chk1("busy_after_done", bus.o_busy, 1'b0);
            end else begin
                exp_stream = !in_bias && (k < N);
                ie_exp = exp_stream && ((k % L) == L - 1);
                ae_exp = exp_stream && ((k / L) == P - 1);
                chk1("busy", bus.o_busy, 1'b1);
                chk1("cmd_ready_busy", bus.o_cmd_ready, 1'b0);
                chk1("bias_enable", bus.o_acc_bias_enable, BIAS_EN);
                chk1("bias_valid", bus.o_acc_bias_valid, in_bias);
                if (in_bias) chkw("bias_data", bus.o_acc_bias_data, v.bias);
                chk1("psum_valid", bus.o_acc_psum_valid, exp_stream && bus.i_psum_valid);
                chk1("psum_ready", bus.o_psum_ready, exp_stream && bus.i_acc_psum_ready);
                chk1("inter_end", bus.o_acc_inter_end, ie_exp);
                chk1("accum_end", bus.o_acc_accum_end, ae_exp);
                if (exp_stream && bus.i_psum_valid)
                    chkw("psum_data", bus.o_acc_psum_data, bus.i_psum_data);

                out_hs = bus.i_acc_out_valid && bus.i_acc_out_ready;
                if (in_bias && bus.i_acc_bias_ready) in_bias = 1'b0;
                if (exp_stream && bus.i_psum_valid && bus.i_acc_psum_ready) begin
                    if (ie_exp) n_ie++;
                    if (ae_exp) begin
                        n_ae++;
                        pending++;
                    end
                    k++;
                end
                if (out_hs) begin
                    pending--;
                    outs++;
                    if (outs == L) exp_done = 1'b1;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (cyc >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL tile_timeout: %0d beats after %0d cycles, want %0d beats", k, cyc, N);
        end
        beats = k;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[NVEC];
        int   beats, nie, nae, nd;
        int   rl, rp;

        rl = int'($urandom_range(0, 63));
        rp = int'($urandom_range(0, 3));
        //          len pass bias          vpct prdy ordy abort beats  inter accum done
        vt[0] = '{63,  1,  32'h3FC0_0000, 100, 100, 100, -1,  128,   2,   64,  1};
        vt[1] = '{15,  2,  32'hC049_0FDB,  90,  33,  33, -1,   48,   3,   16,  1};
        vt[2] = '{ 0,  0,  32'h3F80_0000, 100, 100, 100, -1,    1,   1,    1,  1};
        vt[3] = '{ 3, 255, 32'h0000_0000, 100, 100, 100, -1, 1024, 256,    4,  1};
        vt[4] = '{63,  1,  32'h4120_0000, 100, 100, 100, 10,   10,   0,    0,  0};
        vt[5] = '{ 7,  1,  32'h4000_0000,  90,  50,  50, -1,   16,   2,    8,  1};
        vt[6] = '{rl, rp,  $urandom,       85,  60,  60, -1, (rl + 1) * (rp + 1), rp + 1, rl + 1, 1};

        idle_inputs();
        bus.i_psum_valid     = 1'b1;
        bus.i_acc_psum_ready = 1'b1;
        #2;
        check_cleared("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_cleared("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            run_tile(vt[i], beats, nie, nae, nd);
            chkw($sformatf("tile%0d_beats", i), beats, vt[i].exp_beats);
            chkw($sformatf("tile%0d_inter_ends", i), nie, vt[i].exp_inter);
            chkw($sformatf("tile%0d_accum_ends", i), nae, vt[i].exp_accum);
            chkw($sformatf("tile%0d_done_pulses", i), nd, vt[i].exp_done);
            if (vt[i].abort_at >= 0) begin
                bus.i_psum_valid     = 1'b1;
                bus.i_acc_psum_ready = 1'b1;
                bus.i_acc_out_valid  = 1'b1;
                bus.i_acc_out_ready  = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                check_cleared("abort_reset");
                repeat (3) begin
                    @(posedge clk); #1;
                    check_cleared("abort_hold");
                end
                #3;
                rst_n = 1'b1;
                @(posedge clk); #1;
                idle_inputs();
                #1;
                check_cleared("abort_release");
            end else begin
                @(posedge clk); #1;
                chk1($sformatf("tile%0d_done_single", i), bus.o_done, 1'b0);
                chk1($sformatf("tile%0d_idle_gap", i), bus.o_cmd_ready, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
